// File: rtl/deserializer_task_9_pkg.sv
// Shared types and constants for the 4-lane byte deserializer.
package deserializer_task_9_pkg;

    localparam int LANES  = 4;
    localparam int BYTE_W = 8;
    localparam int CNT_W  = $clog2(LANES);

    typedef logic [BYTE_W-1:0] byte_t;
    // Packed so a whole frame can live in one FIFO word; index 0 = first byte.
    typedef byte_t [LANES-1:0] frame_t;

    typedef enum logic [0:0] {
        s_IDLE    = 1'b0,
        s_COLLECT = 1'b1
    } collector_state_t;

    // Lane index following idx; wraps from LANES-1 back to 0.
    function automatic logic [CNT_W-1:0] lane_next(input logic [CNT_W-1:0] idx);
        return idx + CNT_W'(1);
    endfunction

endpackage

// File: rtl/deserializer_fifo_task_9.sv
// Synchronous frame FIFO with show-ahead read data (q is the head entry).
// A write while full is accepted only when a read happens in the same cycle.
module deserializer_fifo_task_9
    import deserializer_task_9_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   sclr,
    input  logic                   wrreq,
    input  logic                   rdreq,
    input  frame_t                 data,
    output frame_t                 q,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] usedw
);

    localparam int AW = $clog2(DEPTH);

    frame_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;
    logic            wr_s;
    logic            rd_s;

    // Qualify requests against the current fill state.
    always_comb begin
        rd_s = rdreq && (count_q != '0);
        wr_s = wrreq && ((count_q != (AW+1)'(DEPTH)) || rd_s);
    end

    // Storage array; contents need no reset because the pointers gate reads.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_q[wr_ptr_q] <= data;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (sclr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({wr_s, rd_s})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign q     = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign usedw = count_q;

endmodule

// File: rtl/deserializer_task_9.sv
// Byte-stream to 4-byte frame deserializer with frame FIFO and registered
// first-word-fall-through output stage.
// Optional feature: define DESERIALIZER_TIMEOUT_EN to discard partial frames
// after TIMEOUT idle cycles (sticky o_timeout). Without it o_timeout is 0.
module deserializer_task_9
    import deserializer_task_9_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [7:0]             i_data,
    input  logic                   i_valid,
    output logic [7:0]             o_data [4],
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_busy,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_overflow,
    output logic                   o_timeout
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
        $error("deserializer_task_9: DEPTH must be a power of two >= 2, TIMEOUT >= 1");
    end

    // Collector
    collector_state_t  state_q, state_d;
    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    frame_t            lanes_q;
    frame_t            done_frame_s;
    logic              lane_we_s;
    logic              frame_done_s;
    logic              timeout_hit_s;
    logic              push_q;
    frame_t            push_frame_q;
    logic              busy_q;

    // Output stage / FIFO glue
    frame_t            out_frame_q;
    logic              out_valid_q;
    logic              overflow_q;
    logic              out_load_s;
    logic              fifo_pop_s;
    logic              fifo_push_s;
    logic              bypass_s;
    logic              drop_s;
    frame_t            fifo_q_s;
    logic              fifo_empty_s;
    logic              fifo_full_s;
    logic [$clog2(DEPTH):0] fifo_usedw_s;

`ifdef DESERIALIZER_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0] idle_q;
    logic              timeout_q;

    // A byte arriving on the expiry cycle wins over the timeout.
    assign timeout_hit_s = (byte_cnt_q != '0) && !i_valid &&
                           (idle_q == IDLE_W'(TIMEOUT - 1));

    // Idle counter runs only while a partial frame is held.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (i_valid || (byte_cnt_q == '0) || timeout_hit_s) begin
                idle_q <= '0;
            end else begin
                idle_q <= idle_q + IDLE_W'(1);
            end
            if (timeout_hit_s) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign o_timeout = timeout_q;
`else
    assign timeout_hit_s = 1'b0;
    assign o_timeout     = 1'b0;
`endif

    // Collector FSM state and lane registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= s_IDLE;
            byte_cnt_q   <= '0;
            lanes_q      <= '0;
            push_q       <= 1'b0;
            push_frame_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            if (lane_we_s) begin
                lanes_q[byte_cnt_q] <= i_data;
            end
            push_q <= frame_done_s;
            if (frame_done_s) begin
                push_frame_q <= done_frame_s;
            end
            busy_q <= (byte_cnt_q != '0);
        end
    end

    // Collector FSM next-state and byte counter.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        case (state_q)
            s_IDLE: begin
                if (i_valid) begin
                    state_d    = s_COLLECT;
                    byte_cnt_d = CNT_W'(1);
                end else begin
                    state_d    = s_IDLE;
                end
            end
            s_COLLECT: begin
                if (i_valid) begin
                    byte_cnt_d = lane_next(byte_cnt_q);
                    if (byte_cnt_q == CNT_W'(LANES - 1)) begin
                        state_d = s_IDLE;
                    end else begin
                        state_d = s_COLLECT;
                    end
                end else if (timeout_hit_s) begin
                    state_d    = s_IDLE;
                    byte_cnt_d = '0;
                end else begin
                    state_d    = s_COLLECT;
                end
            end
            default: begin
                state_d    = s_IDLE;
                byte_cnt_d = '0;
            end
        endcase
    end

    // Collector FSM outputs: lane write strobe and completed-frame assembly.
    always_comb begin
        lane_we_s    = 1'b0;
        frame_done_s = 1'b0;
        done_frame_s = lanes_q;
        case (state_q)
            s_IDLE: begin
                lane_we_s = i_valid;
            end
            s_COLLECT: begin
                lane_we_s    = i_valid;
                frame_done_s = i_valid && (byte_cnt_q == CNT_W'(LANES - 1));
            end
            default: begin
                lane_we_s = 1'b0;
            end
        endcase
        done_frame_s[byte_cnt_q] = i_data;
    end

    // Output-stage steering: FIFO head first, else a fresh push bypasses the FIFO.
    always_comb begin
        out_load_s  = !out_valid_q || i_ready;
        fifo_pop_s  = out_load_s && !fifo_empty_s;
        bypass_s    = out_load_s && fifo_empty_s && push_q;
        fifo_push_s = push_q && !bypass_s;
        drop_s      = fifo_push_s && fifo_full_s && !fifo_pop_s;
    end

    deserializer_fifo_task_9 #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .sclr  (i_rst),
        .wrreq (fifo_push_s && !drop_s),
        .rdreq (fifo_pop_s),
        .data  (push_frame_q),
        .q     (fifo_q_s),
        .empty (fifo_empty_s),
        .full  (fifo_full_s),
        .usedw (fifo_usedw_s)
    );

    // Output register and sticky overflow flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_frame_q <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (fifo_pop_s) begin
                out_frame_q <= fifo_q_s;
                out_valid_q <= 1'b1;
            end else if (bypass_s) begin
                out_frame_q <= push_frame_q;
                out_valid_q <= 1'b1;
            end else if (out_load_s) begin
                out_valid_q <= 1'b0;
            end else begin
                out_valid_q <= out_valid_q;
            end
            if (drop_s) begin
                overflow_q <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_out_lane
        assign o_data[g] = out_frame_q[g];
    end

    assign o_valid    = out_valid_q;
    assign o_busy     = busy_q;
    assign o_level    = fifo_usedw_s;
    assign o_overflow = overflow_q;

endmodule

// File: tb/tb_deserializer_task_9.sv
// Scoreboard bench for deserializer_task_9: stimulus pushes expected frames,
// an independent negedge monitor pops and compares on every output transfer.
module tb_deserializer_task_9;

    localparam int DEPTH = 8;
    localparam int TO    = 16;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [7:0]  i_data;
    logic        i_valid;
    logic [7:0]  o_data [4];
    logic        o_valid;
    logic        i_ready;
    logic        o_busy;
    logic [$clog2(DEPTH):0] o_level;
    logic        o_overflow;
    logic        o_timeout;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    bit          rand_mode = 1'b0;
    int          stall_run = 0;

    deserializer_task_9 #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_busy     (o_busy),
        .o_level    (o_level),
        .o_overflow (o_overflow),
        .o_timeout  (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] out_word();
        return {o_data[3], o_data[2], o_data[1], o_data[0]};
    endfunction

    // Advance one cycle; in random mode pick i_ready with stalls of at most 3 cycles.
    task automatic tick();
        if (rand_mode) begin
            if (stall_run >= 3) i_ready = 1'b1;
            else                i_ready = 1'($urandom_range(0, 1));
            stall_run = i_ready ? 0 : stall_run + 1;
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_valid = 1'b1;
        i_data  = b;
        tick();
        i_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] f, input int gap, input bit keep);
        for (int b = 0; b < 4; b++) begin
            send_byte(f[8*b +: 8]);
            if (b == 3 && keep) exp_q.push_back(f);
            repeat (gap) tick();
        end
    endtask

    task automatic do_reset();
        i_rst   = 1'b1;
        i_valid = 1'b0;
        exp_q.delete();
        tick();
        i_rst = 1'b0;
    endtask

    task automatic drain();
        i_ready = 1'b1;
        for (int k = 0; k < 400 && (exp_q.size() != 0 || o_valid); k++) tick();
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // One frame with 'gap' idle cycles between bytes; checks o_busy every cycle
    // (busy = a partial frame existed in the previous cycle) and the output latency.
    task automatic frame_busy(input logic [31:0] f, input int gap);
        int cnt  = 0;
        int prev = 0;
        int kl   = 3 * (gap + 1);
        for (int k = 0; k < kl + 5; k++) begin
            bit v;
            v = (k % (gap + 1) == 0) && (k / (gap + 1) < 4);
            i_valid = v;
            if (v) i_data = f[8*(k/(gap+1)) +: 8];
            @(negedge i_clk);
            chk($sformatf("busy_c%0d_g%0d", k, gap), 32'(o_busy), 32'(prev != 0));
            if (k == kl + 1) chk("latency_n1", 32'(o_valid), 32'd0);
            if (k == kl + 2) chk("latency_n2", 32'(o_valid), 32'd1);
            prev = cnt;
            if (v) begin
                cnt = (cnt + 1) % 4;
                if (cnt == 0) exp_q.push_back(f);
            end
            @(posedge i_clk);
            #1;
        end
        i_valid = 1'b0;
    endtask

    // Monitor: compares every transfer against the scoreboard and checks hold-stability.
    bit          stall_seen = 1'b0;
    logic [31:0] stall_data = '0;
    always @(negedge i_clk) begin
        if (i_rst) begin
            stall_seen = 1'b0;
        end else begin
            if (stall_seen) begin
                chk("hold_valid", 32'(o_valid), 32'd1);
                chk("hold_data", out_word(), stall_data);
            end
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", out_word(), 32'hxxxx_xxxx);
                end else begin
                    chk("frame", out_word(), exp_q.pop_front());
                end
            end
            stall_seen = o_valid && !i_ready;
            stall_data = out_word();
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] fr;
        i_rst = 1'b1; i_valid = 1'b0; i_data = 8'h00; i_ready = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_level", 32'(o_level), 32'd0);
        chk("rst_overflow", 32'(o_overflow), 32'd0);
        chk("rst_timeout", 32'(o_timeout), 32'd0);
        chk("rst_data", out_word(), 32'd0);
        @(posedge i_clk);
        #1;

        // Back-to-back bytes, then the same bytes with 5-cycle gaps.
        i_ready = 1'b1;
        frame_busy(32'h44332211, 0);
        frame_busy(32'h44332211, 5);
        drain();

        // Long idle inside a partial frame.
        do_reset();
        i_ready = 1'b1;
        send_byte(8'hC0);
        send_byte(8'hC1);
        repeat (TO) tick();
`ifdef DESERIALIZER_TIMEOUT_EN
        chk("to_busy_cleared", 32'(o_busy), 32'd0);
        send_frame(32'hB3B2B1B0, 0, 1'b1);
        drain();
        chk("to_sticky", 32'(o_timeout), 32'd1);
`else
        chk("idle_busy_held", 32'(o_busy), 32'd1);
        send_byte(8'hC2);
        send_byte(8'hC3);
        exp_q.push_back(32'hC3C2C1C0);
        drain();
        chk("no_timeout", 32'(o_timeout), 32'd0);
`endif

        // Overflow: DEPTH+2 frames with consumer stalled, one is dropped.
        do_reset();
        i_ready = 1'b0;
        for (int f = 0; f < DEPTH + 2; f++) send_frame($urandom, 0, f <= DEPTH);
        repeat (4) tick();
        chk("ovf_level", 32'(o_level), 32'(DEPTH));
        chk("ovf_valid", 32'(o_valid), 32'd1);
        chk("ovf_flag", 32'(o_overflow), 32'd1);
        drain();
        chk("ovf_sticky", 32'(o_overflow), 32'd1);
        chk("ovf_level_empty", 32'(o_level), 32'd0);

        // Full FIFO, consumer pulses ready exactly when the push arrives.
        do_reset();
        i_ready = 1'b0;
        for (int f = 0; f <= DEPTH; f++) send_frame($urandom, 0, 1'b1);
        repeat (3) tick();
        chk("full_level", 32'(o_level), 32'(DEPTH));
        fr = $urandom;
        send_byte(fr[7:0]);
        send_byte(fr[15:8]);
        send_byte(fr[23:16]);
        send_byte(fr[31:24]);
        exp_q.push_back(fr);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        repeat (2) tick();
        chk("pulse_level", 32'(o_level), 32'(DEPTH));
        chk("pulse_no_ovf", 32'(o_overflow), 32'd0);
        drain();

        // Reset in the middle of a frame discards the partial lanes.
        i_ready = 1'b1;
        send_byte(8'hEE);
        send_byte(8'hEF);
        do_reset();
        chk("midrst_busy", 32'(o_busy), 32'd0);
        send_frame(32'hA3A2A1A0, 0, 1'b1);
        drain();

        // Random frames, random byte gaps, random short consumer stalls.
        rand_mode = 1'b1;
        for (int f = 0; f < 120; f++) send_frame($urandom, $urandom_range(0, 3), 1'b1);
        rand_mode = 1'b0;
        drain();
        chk("rand_no_ovf", 32'(o_overflow), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
